fpu_dispatch: RTL and testbench
===============================

# fpu_dispatch

Command issuer that drives the FPU register-file command port from the CPU side. It accepts one decoded floating-point instruction at a time from the integer pipeline and presents it to the FPU with the `ready`/`valid` handshake. It captures the FPU result (`out_data1` for compare, `out_data32` for get/ftoi) and returns a completion to the pipeline, inserting the mandatory idle cycle the FPU needs after each command.

## Interface
Parameters:
- `TIMEOUT`, 1023: max cycles in ISSUE without `fpu_valid` before abort (only with watchdog compiled in); counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline presents a command.
- `req_ready`  out  1  dispatcher accepts command (IDLE only).
- `req_op`  in  6  FPU opcode.
- `req_x1`, `req_x2`, `req_y`  in  5 each  FPU source/destination register indices.
- `req_data`  in  32  integer operand for SET/ITOF.
- `fpu_operation`  out  6  to FPU `operation`.
- `fpu_x1`, `fpu_x2`, `fpu_y`  out  5 each  to FPU `x1`/`x2`/`y`.
- `fpu_in_data`  out  32  to FPU `in_data`.
- `fpu_ready`  out  1  to FPU `ready`.
- `fpu_valid`  in  1  from FPU `valid`.
- `fpu_out_data1`  in  1  from FPU `out_data1`.
- `fpu_out_data32`  in  32  from FPU `out_data32`.
- `rsp_valid`  out  1  completion available.
- `rsp_ready`  in  1  pipeline consumes completion.
- `rsp_data`  out  32  result word.
- `rsp_err`  out  1  completion is an error (bad opcode or timeout).

## Operation
- Legal opcodes: FNEG 010000, FADD 000000, FSUB 000001, FMUL 000010, FCLT 100000, FTOI 111000, ITOF 111001, MOV 111101, SET 111110, GET 111111. Any other value is illegal.
- States: IDLE, ISSUE, RESP.
- IDLE: `req_ready`=1. On `req_valid&&req_ready`, latch op/x1/x2/y/data. Legal opcode → ISSUE. Illegal opcode → RESP with `rsp_err`=1, `rsp_data`=0, FPU untouched.
- ISSUE: `fpu_ready`=1. All `fpu_*` fields are driven from latched registers and stay stable. `fpu_in_data` = latched data for SET/ITOF, else 0. Sample `fpu_valid` each cycle; when it is 1, capture the result and → RESP:
  - FCLT: `rsp_data`={31'b0, `fpu_out_data1`}.
  - FTOI, GET: `rsp_data`=`fpu_out_data32`.
  - All other ops: `rsp_data`=0.
- RESP: `rsp_valid`=1 and `fpu_ready`=0. `rsp_data`/`rsp_err` are held until `rsp_valid&&rsp_ready`, then → IDLE.
- `fpu_*` fields outside ISSUE: 0.

## Timing
- Reset (async): state=IDLE, every output 0, including `req_ready` (held 0 while `rstn`=0, asserts 1 the first cycle after release).
- Reset mid-ISSUE: `fpu_ready` drops immediately; the command is discarded and no completion is produced.
- Accept at edge N → `fpu_ready` high in cycle N+1.
- MOV/SET/GET: `fpu_valid` is combinational in the same cycle, so `rsp_valid` is in cycle N+2.
- Multi-cycle ops: `rsp_valid` appears the cycle after `fpu_valid` is sampled.
- `fpu_valid` is ignored outside ISSUE.
- RESP lasts ≥1 cycle with `fpu_ready`=0, which guarantees the FPU's post-command write cycle. Minimum command spacing is 3 cycles.
- `rsp_ready` held high: RESP lasts exactly 1 cycle. `rsp_ready` low: the dispatcher stalls, and `req_ready` stays 0.
- Illegal opcode: `rsp_valid` in cycle N+1.

## Configuration
- `FPU_DISPATCH_TIMEOUT_EN` defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle without `fpu_valid`.
  - When the count equals `TIMEOUT` → RESP with `rsp_err`=1, `rsp_data`=32'hFFFF_FFFF, and `fpu_ready` drops.
  - `fpu_valid` in the same cycle as expiry wins (normal completion).
- Undefined: no counter; ISSUE waits indefinitely for `fpu_valid`.

## Test plan
- Reset release, then SET y=3 data=32'h3F80_0000 with `fpu_valid` combinational → `fpu_ready` 1 cycle, `fpu_in_data`=3F800000, `rsp_valid` at N+2, `rsp_data`=0, `rsp_err`=0.
- GET x1=3 with FPU model returning 32'h3F80_0000 → `rsp_data`=3F800000; next `req_ready` no earlier than 3 cycles after the previous accept.
- FADD x1=1 x2=2 y=4, model asserts `fpu_valid` after 5 cycles → `fpu_ready` high exactly 5 cycles with stable fields, then 0 in RESP.
- FCLT, model `out_data1`=1 → `rsp_data`=1.
- Illegal opcode 6'b000111 → `fpu_ready` never asserts, `rsp_err`=1 at N+1.
- Backpressure: `rsp_ready` low 4 cycles → `rsp_*` stable, `req_ready`=0.
- Reset asserted mid-ISSUE → outputs 0 immediately, no `rsp_valid` after release.
- With `FPU_DISPATCH_TIMEOUT_EN` and `TIMEOUT`=8, FPU never valid → `rsp_err`=1, `rsp_data`=FFFFFFFF after 8 ISSUE cycles.

Source files
------------

// File: rtl/fpu_dispatch.sv
// Issues one decoded FP instruction at a time to the FPU command port and returns its completion.
// Optional watchdog on the ISSUE wait: define FPU_DISPATCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a pipeline command (req_ready=1)
// ISSUE | command presented to the FPU (fpu_ready=1) until fpu_valid
// RESP  | completion held on rsp_* until consumed; also the FPU's idle cycle
module fpu_dispatch #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [4:0]  req_x1,
    input  logic [4:0]  req_x2,
    input  logic [4:0]  req_y,
    input  logic [31:0] req_data,
    output logic [5:0]  fpu_operation,
    output logic [4:0]  fpu_x1,
    output logic [4:0]  fpu_x2,
    output logic [4:0]  fpu_y,
    output logic [31:0] fpu_in_data,
    output logic        fpu_ready,
    input  logic        fpu_valid,
    input  logic        fpu_out_data1,
    input  logic [31:0] fpu_out_data32,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [5:0] OP_FADD = 6'b000000;
    localparam logic [5:0] OP_FSUB = 6'b000001;
    localparam logic [5:0] OP_FMUL = 6'b000010;
    localparam logic [5:0] OP_FNEG = 6'b010000;
    localparam logic [5:0] OP_FCLT = 6'b100000;
    localparam logic [5:0] OP_FTOI = 6'b111000;
    localparam logic [5:0] OP_ITOF = 6'b111001;
    localparam logic [5:0] OP_MOV  = 6'b111101;
    localparam logic [5:0] OP_SET  = 6'b111110;
    localparam logic [5:0] OP_GET  = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  x1_q, x1_d, x2_q, x2_d, y_q, y_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        op_legal;

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        unique case (req_op)
            OP_FADD, OP_FSUB, OP_FMUL, OP_FNEG, OP_FCLT,
            OP_FTOI, OP_ITOF, OP_MOV, OP_SET, OP_GET: op_legal = 1'b1;
            default:                                  op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            y_q        <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y_q        <= y_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y_d        = y_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    x1_d       = req_x1;
                    x2_d       = req_x2;
                    y_d        = req_y;
                    data_d     = req_data;
                    rsp_data_d = '0;
                    // Illegal opcodes bypass the FPU entirely and complete with an error.
                    rsp_err_d  = !op_legal;
                    state_d    = op_legal ? S_ISSUE : S_RESP;
`ifdef FPU_DISPATCH_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (fpu_valid) begin
                    state_d   = S_RESP;
                    rsp_err_d = 1'b0;
                    unique case (op_q)
                        OP_FCLT:         rsp_data_d = {31'b0, fpu_out_data1};
                        OP_FTOI, OP_GET: rsp_data_d = fpu_out_data32;
                        default:         rsp_data_d = '0;
                    endcase
                end
`ifdef FPU_DISPATCH_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'hFFFF_FFFF;
                    end
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        fpu_ready     = 1'b0;
        fpu_operation = '0;
        fpu_x1        = '0;
        fpu_x2        = '0;
        fpu_y         = '0;
        fpu_in_data   = '0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_err       = 1'b0;
        unique case (state_q)
            // Gated by rstn so the pipeline never sees ready while reset is held.
            S_IDLE: req_ready = rstn;
            S_ISSUE: begin
                fpu_ready     = 1'b1;
                fpu_operation = op_q;
                fpu_x1        = x1_q;
                fpu_x2        = x2_q;
                fpu_y         = y_q;
                fpu_in_data   = (op_q == OP_SET || op_q == OP_ITOF) ? data_q : '0;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_data_q;
                rsp_err   = rsp_err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Randomized scoreboard bench for fpu_dispatch with a latency-programmable FPU model.
// Build with FPU_DISPATCH_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_fpu_dispatch;

    localparam int unsigned TO = 8;

    localparam logic [5:0] FADD = 6'b000000;
    localparam logic [5:0] FCLT = 6'b100000;
    localparam logic [5:0] FTOI = 6'b111000;
    localparam logic [5:0] ITOF = 6'b111001;
    localparam logic [5:0] SET  = 6'b111110;
    localparam logic [5:0] GET  = 6'b111111;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [4:0]  req_x1 = '0, req_x2 = '0, req_y = '0;
    logic [31:0] req_data = '0;
    logic [5:0]  fpu_operation;
    logic [4:0]  fpu_x1, fpu_x2, fpu_y;
    logic [31:0] fpu_in_data;
    logic        fpu_ready;
    logic        fpu_valid;
    logic        fpu_out_data1 = 1'b0;
    logic [31:0] fpu_out_data32 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;

    always #5 clk = ~clk;

    fpu_dispatch #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_x2(req_x2), .req_y(req_y), .req_data(req_data),
        .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
        .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
        .fpu_out_data1(fpu_out_data1), .fpu_out_data32(fpu_out_data32),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // FPU model: valid once fpu_ready has been high for lat_tgt+1 cycles; random noise when not ready.
    int   lat_tgt = 0;
    int   lat_cnt = 0;
    logic noise = 1'b0;
    always @(posedge clk) begin
        lat_cnt <= fpu_ready ? lat_cnt + 1 : 0;
        noise   <= 1'($urandom_range(0, 1));
    end
    always_comb fpu_valid = fpu_ready ? (lat_cnt >= lat_tgt) : noise;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];
    int   n_pushed = 0;
    int   n_popped = 0;

    logic [5:0] legal_ops [10] = '{6'b010000, 6'b000000, 6'b000001, 6'b000010, 6'b100000,
                                   6'b111000, 6'b111001, 6'b111101, 6'b111110, 6'b111111};

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic rsp_t model(input logic [5:0] op, input logic o1, input logic [31:0] o32);
        rsp_t r;
        r.err  = !is_legal(op);
        r.data = 32'd0;
        if (!r.err) begin
            if (op == FCLT)                   r.data = {31'b0, o1};
            else if (op == FTOI || op == GET) r.data = o32;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        if (rstn && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=%h required=none", rsp_data);
            end else begin
                e = sb_q.pop_front();
                n_popped++;
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Issue one command and follow it through ISSUE and RESP. Called at posedge+1.
    task automatic run_cmd(input logic [5:0] op, input logic [4:0] x1, input logic [4:0] x2,
                           input logic [4:0] y, input logic [31:0] data, input logic o1,
                           input logic [31:0] o32, input int lat, input int exp_len,
                           input int stall, input bit expect_timeout);
        int   waited = 0;
        int   rc = 0;
        rsp_t e;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        req_op = op; req_x1 = x1; req_x2 = x2; req_y = y; req_data = data;
        req_valid = 1'b1;
        fpu_out_data1 = o1; fpu_out_data32 = o32;
        lat_tgt = lat;
        rsp_ready = (stall == 0);
        e = model(op, o1, o32);
        if (expect_timeout) begin
            e.data = 32'hFFFF_FFFF;
            e.err  = 1'b1;
        end
        sb_q.push_back(e);
        n_pushed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 6'($urandom); req_x1 = 5'($urandom); req_x2 = 5'($urandom);
        req_y = 5'($urandom); req_data = $urandom;
        if (is_legal(op)) begin
            while (fpu_ready && rc < 2000) begin
                chk("fpu_operation", 32'(fpu_operation), 32'(op));
                chk("fpu_x1", 32'(fpu_x1), 32'(x1));
                chk("fpu_x2", 32'(fpu_x2), 32'(x2));
                chk("fpu_y", 32'(fpu_y), 32'(y));
                chk("fpu_in_data", fpu_in_data, (op == SET || op == ITOF) ? data : 32'd0);
                chk("req_ready_issue", 32'(req_ready), 32'd0);
                rc++;
                @(posedge clk); #1;
            end
            chk("issue_len", 32'(rc), 32'(exp_len));
        end else begin
            chk("illegal_fpu_ready", 32'(fpu_ready), 32'd0);
        end
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_fpu_ready", 32'(fpu_ready), 32'd0);
        chk("resp_fpu_operation", 32'(fpu_operation), 32'd0);
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data", rsp_data, e.data);
            chk("stall_rsp_err", 32'(rsp_err), 32'(e.err));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [5:0] op;
        int         lat;
        int         stall;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fpu_ready", 32'(fpu_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_fpu_operation", 32'(fpu_operation), 32'd0);
        chk("rst_fpu_in_data", fpu_in_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Directed cases
        run_cmd(SET, 5'd0, 5'd0, 5'd3, 32'h3F80_0000, 1'b0, 32'h1234_5678, 0, 1, 0, 1'b0);
        run_cmd(GET, 5'd3, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'h3F80_0000, 0, 1, 0, 1'b0);
        run_cmd(FADD, 5'd1, 5'd2, 5'd4, 32'h0000_0055, 1'b1, 32'hCAFE_F00D, 4, 5, 0, 1'b0);
        run_cmd(FCLT, 5'd5, 5'd6, 5'd0, 32'h0, 1'b1, 32'hFFFF_0000, 2, 3, 0, 1'b0);
        run_cmd(6'b000111, 5'd7, 5'd8, 5'd9, 32'h1, 1'b1, 32'h5555_AAAA, 0, 0, 0, 1'b0);
        run_cmd(FTOI, 5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0000_002A, 3, 4, 4, 1'b0);

        // Reset in the middle of a command
        while (!req_ready) begin @(posedge clk); #1; end
        req_op = FADD; req_x1 = 5'd1; req_x2 = 5'd2; req_y = 5'd3; req_valid = 1'b1;
        lat_tgt = 20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_fpu_ready", 32'(fpu_ready), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_fpu_ready", 32'(fpu_ready), 32'd0);
        chk("mid_rst_fpu_operation", 32'(fpu_operation), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("mid_rel_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid_rel_no_fpu", 32'(fpu_ready), 32'd0);
            @(posedge clk); #1;
        end

`ifdef FPU_DISPATCH_TIMEOUT_EN
        run_cmd(FADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h0, 1000, int'(TO), 0, 1'b1);
        run_cmd(FADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h0, int'(TO) - 1, int'(TO), 0, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                op = legal_ops[$urandom_range(0, 9)];
            end else begin
                op = 6'($urandom);
                for (int t = 0; t < 20 && is_legal(op); t++) op = 6'($urandom);
                if (is_legal(op)) op = 6'b000111;
            end
            lat   = int'($urandom_range(0, 6));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_cmd(op, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
                    1'($urandom), $urandom, lat, lat + 1, stall, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("rsp_count", 32'(n_popped), 32'(n_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
